// File: rtl/timer_irq_if.sv
// Bus bundle between the CPU data-memory stage and the timer_irq peripheral.
// The CPU side uses the master modport; the timer uses the slave modport.
interface timer_irq_if #(
    parameter int unsigned WIDTH = 32
);
    logic [31:0]      Addr;
    logic [WIDTH-1:0] WriteData;
    logic             MemRd;
    logic             MemWr;
    logic [WIDTH-1:0] ReadData;
    logic             Hit;
    logic             IRQ;

    modport master (
        output Addr,
        output WriteData,
        output MemRd,
        output MemWr,
        input  ReadData,
        input  Hit,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WriteData,
        input  MemRd,
        input  MemWr,
        output ReadData,
        output Hit,
        output IRQ
    );
endinterface

// File: rtl/timer_irq.sv
// timer_irq: memory-mapped interval timer with a level interrupt request.
//
// Register map (word offsets from BASE_ADDR):
//   0x00 TH      reload value, R/W
//   0x04 TL      counter, R/W
//   0x08 TCON    bit0 EN, bit1 IE, bit2 STAT; other bits read 0
//   0x0C PRESC   16-bit prescaler, R/W (only when TIMER_PRESCALE_EN is defined)
//   0x14 SYSTICK free-running cycle counter, read-only
//
// Optional feature macro: TIMER_PRESCALE_EN. When defined, TL advances only
// once every (PRESC + 1) enabled cycles. When undefined, offset 0x0C does not
// decode and TL advances on every enabled cycle.
//
// IRQ = STAT & IE is purely combinational from the registers, so an
// asynchronous reset drops it immediately.
module timer_irq #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned WIDTH     = 32
) (
    input  logic       clk,
    input  logic       reset,
    timer_irq_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] th_q, th_d;
    logic [WIDTH-1:0] tl_q, tl_d;
    logic [WIDTH-1:0] systick_q, systick_d;
    logic             en_q, en_d;
    logic             ie_q, ie_d;
    logic             stat_q, stat_d;

`ifdef TIMER_PRESCALE_EN
    logic [15:0]      presc_q, presc_d;
    logic [15:0]      pcnt_q, pcnt_d;
    logic             sel_presc;
    logic             wr_presc;
`endif

    // ------------------------------------------------------------------
    // Decode / control
    // ------------------------------------------------------------------
    logic             blk_match;
    logic             sel_th, sel_tl, sel_tcon, sel_systick;
    logic             hit;
    logic             wr_en;
    logic             wr_th, wr_tl, wr_tcon;
    logic             tick;
    logic             ovf;
    logic [WIDTH-1:0] rdata;

    // Address decode: upper bits select the block, low five bits the register.
    always_comb begin
        blk_match   = (bus.Addr[31:5] == BASE_ADDR[31:5]);
        sel_th      = blk_match && (bus.Addr[4:0] == 5'h00);
        sel_tl      = blk_match && (bus.Addr[4:0] == 5'h04);
        sel_tcon    = blk_match && (bus.Addr[4:0] == 5'h08);
        sel_systick = blk_match && (bus.Addr[4:0] == 5'h14);
`ifdef TIMER_PRESCALE_EN
        sel_presc   = blk_match && (bus.Addr[4:0] == 5'h0C);
        hit         = sel_th || sel_tl || sel_tcon || sel_systick || sel_presc;
`else
        hit         = sel_th || sel_tl || sel_tcon || sel_systick;
`endif
    end

    // Write strobes; SYSTICK has no strobe because writes to it are ignored.
    always_comb begin
        wr_en   = bus.MemWr && hit;
        wr_th   = wr_en && sel_th;
        wr_tl   = wr_en && sel_tl;
        wr_tcon = wr_en && sel_tcon;
`ifdef TIMER_PRESCALE_EN
        wr_presc = wr_en && sel_presc;
`endif
    end

    // Count qualifier: every enabled cycle, or once per prescaler period.
    always_comb begin
`ifdef TIMER_PRESCALE_EN
        tick = en_q && (pcnt_q == presc_q);
`else
        tick = en_q;
`endif
        ovf = tick && (tl_q == ALL_ONES);
    end

`ifdef TIMER_PRESCALE_EN
    // Prescaler next state: cycles 0..PRESC while enabled, restarts on reprogramming.
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        if (en_q) begin
            if (pcnt_q == presc_q) begin
                pcnt_d = 16'd0;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end
        if (wr_presc) begin
            presc_d = bus.WriteData[15:0];
            pcnt_d  = 16'd0;
        end
        if (wr_tcon) begin
            pcnt_d = 16'd0;
        end
    end

    // Prescaler registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 16'd0;
            pcnt_q  <= 16'd0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`endif

    // Timer next state. Bus writes override the count update; an overflow
    // with IE set always leaves STAT at 1, even against a TCON or TL write.
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        en_d      = en_q;
        ie_d      = ie_q;
        stat_d    = stat_q;
        systick_d = systick_q + ONE;

        if (tick) begin
            tl_d = ovf ? th_q : (tl_q + ONE);
        end

        if (wr_th) begin
            th_d = bus.WriteData;
        end
        if (wr_tl) begin
            tl_d = bus.WriteData;
        end
        if (wr_tcon) begin
            en_d   = bus.WriteData[0];
            ie_d   = bus.WriteData[1];
            stat_d = bus.WriteData[2];
        end

        if (ovf && ie_q) begin
            stat_d = 1'b1;
        end
    end

    // Timer registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            systick_q <= '0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            stat_q    <= 1'b0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            systick_q <= systick_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            stat_q    <= stat_d;
        end
    end

    // Zero-latency read mux; returns 0 unless this block is being loaded.
    always_comb begin
        rdata = '0;
        if (bus.MemRd && hit) begin
            if (sel_th) begin
                rdata = th_q;
            end else if (sel_tl) begin
                rdata = tl_q;
            end else if (sel_tcon) begin
                rdata = {{(WIDTH-3){1'b0}}, stat_q, ie_q, en_q};
            end else if (sel_systick) begin
                rdata = systick_q;
`ifdef TIMER_PRESCALE_EN
            end else if (sel_presc) begin
                rdata = {{(WIDTH-16){1'b0}}, presc_q};
`endif
            end
        end
    end

    assign bus.ReadData = rdata;
    assign bus.Hit      = hit;
    assign bus.IRQ      = stat_q & ie_q;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: a vector table for decode and register access,
// then hand-written sequences for overflow, clear/mask, races and reset.
module tb_timer_irq;

    localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef TIMER_PRESCALE_EN
    localparam logic PH = 1'b1;
`else
    localparam logic PH = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    timer_irq_if #(.WIDTH(32)) bus ();

    timer_irq #(.BASE_ADDR(BASE), .WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected SYSTICK: cycles since reset release.
    logic [31:0] exp_systick;
    always @(posedge clk or posedge reset) begin
        if (reset) exp_systick <= 32'd0;
        else       exp_systick <= exp_systick + 32'd1;
    end

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rd;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                       input logic rd, input logic [31:0] er, input logic eh,
                       input logic ei);
        vec_t v;
        v.addr = a; v.wdata = wd; v.wr = wr; v.rd = rd;
        v.exp_rdata = er; v.exp_hit = eh; v.exp_irq = ei;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        bus.Addr      = a;
        bus.WriteData = d;
        bus.MemRd     = 1'b0;
        bus.MemWr     = 1'b1;
        tick();
        bus.MemWr     = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        bus.Addr  = a;
        bus.MemRd = 1'b1;
        #1;
        chk(nm, bus.ReadData, exp);
        bus.MemRd = 1'b0;
    endtask

    task automatic irq_chk(input string nm, input logic exp);
        chk(nm, {31'd0, bus.IRQ}, {31'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.Addr      = 32'd0;
        bus.WriteData = 32'd0;
        bus.MemRd     = 1'b0;
        bus.MemWr     = 1'b0;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        irq_chk("rst_irq", 1'b0);
        rd_chk("rst_th", BASE + 32'h00, 32'd0);
        rd_chk("rst_tl", BASE + 32'h04, 32'd0);
        rd_chk("rst_tcon", BASE + 32'h08, 32'd0);
        rd_chk("rst_systick", BASE + 32'h14, 32'd0);
        bus.Addr = BASE + 32'h01;
        #1;
        chk("rst_hit_misaligned", {31'd0, bus.Hit}, 32'd0);
        tick();

        // ---------------- decode / register access table ----------------
        add(BASE + 32'h00, 32'h0,          0, 1, 32'h0,          1,  0);
        add(BASE + 32'h01, 32'h0,          0, 1, 32'h0,          0,  0);
        add(BASE + 32'h00, 32'h1234_5678,  1, 0, 32'h0,          1,  0);
        add(BASE + 32'h00, 32'h0,          0, 1, 32'h1234_5678,  1,  0);
        add(BASE + 32'h04, 32'hCAFE_BABE,  1, 0, 32'h0,          1,  0);
        add(BASE + 32'h04, 32'h0,          0, 1, 32'hCAFE_BABE,  1,  0);
        add(BASE + 32'h08, 32'hFFFF_FFF2,  1, 0, 32'h0,          1,  0);
        add(BASE + 32'h08, 32'h0,          0, 1, 32'h2,          1,  0);
        add(BASE + 32'h08, 32'h0,          0, 0, 32'h0,          1,  0);
        add(BASE + 32'h00, 32'h0000_AAAA,  1, 1, 32'h1234_5678,  1,  0);
        add(BASE + 32'h00, 32'h0,          0, 1, 32'h0000_AAAA,  1,  0);
        add(BASE + 32'h0C, 32'h0,          0, 1, 32'h0,          PH, 0);
        add(BASE + 32'h10, 32'h0,          0, 1, 32'h0,          0,  0);
        add(BASE + 32'h20, 32'h0,          0, 1, 32'h0,          0,  0);
        add(BASE + 32'h02, 32'h0,          0, 1, 32'h0,          0,  0);
        add(32'h5000_0000, 32'h0,          0, 1, 32'h0,          0,  0);
        add(BASE + 32'h14, 32'h0,          1, 0, 32'h0,          1,  0);
        add(BASE + 32'h04, 32'h0,          0, 1, 32'hCAFE_BABE,  1,  0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.Addr      = tbl[i].addr;
            bus.WriteData = tbl[i].wdata;
            bus.MemWr     = tbl[i].wr;
            bus.MemRd     = tbl[i].rd;
            #1;
            chk($sformatf("tbl%0d_hit", i), {31'd0, bus.Hit}, {31'd0, tbl[i].exp_hit});
            chk($sformatf("tbl%0d_rdata", i), bus.ReadData, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_irq", i), {31'd0, bus.IRQ}, {31'd0, tbl[i].exp_irq});
            tick();
            bus.MemWr = 1'b0;
            bus.MemRd = 1'b0;
        end
        rd_chk("systick_after_table", BASE + 32'h14, exp_systick);

        // ---------------- overflow and reload ----------------
        wr_reg(BASE + 32'h00, 32'hFFFF_FFFC);
        wr_reg(BASE + 32'h04, 32'hFFFF_FFFC);
        wr_reg(BASE + 32'h08, 32'h3);
        rd_chk("ovf_tl_e0", BASE + 32'h04, 32'hFFFF_FFFC);
        irq_chk("ovf_irq_e0", 1'b0);
        for (int k = 1; k <= 8; k++) begin
            logic [31:0] exp_tl;
            tick();
            case (k % 4)
                1:       exp_tl = 32'hFFFF_FFFD;
                2:       exp_tl = 32'hFFFF_FFFE;
                3:       exp_tl = 32'hFFFF_FFFF;
                default: exp_tl = 32'hFFFF_FFFC;
            endcase
            rd_chk($sformatf("ovf_tl_e%0d", k), BASE + 32'h04, exp_tl);
            irq_chk($sformatf("ovf_irq_e%0d", k), (k >= 4));
        end

        // ---------------- clear and mask ----------------
        wr_reg(BASE + 32'h08, 32'h3);            // TL FC -> FD, STAT cleared
        irq_chk("clr_irq", 1'b0);
        rd_chk("clr_tcon", BASE + 32'h08, 32'h3);
        wr_reg(BASE + 32'h08, 32'h5);            // IE = 0, STAT = 1; TL -> FE
        irq_chk("mask_irq", 1'b0);
        rd_chk("mask_tcon", BASE + 32'h08, 32'h5);
        wr_reg(BASE + 32'h08, 32'h7);            // unmask; TL -> FF
        irq_chk("unmask_irq", 1'b1);

        // ---------------- set-wins race ----------------
        wr_reg(BASE + 32'h08, 32'h0);
        wr_reg(BASE + 32'h04, 32'hFFFF_FFFE);
        wr_reg(BASE + 32'h08, 32'h3);            // EN was 0: TL holds FE
        rd_chk("race_tl_hold", BASE + 32'h04, 32'hFFFF_FFFE);
        tick();                                  // FE -> FF
        rd_chk("race_tl_pre", BASE + 32'h04, 32'hFFFF_FFFF);
        irq_chk("race_irq_pre", 1'b0);
        wr_reg(BASE + 32'h08, 32'h3);            // write lands on overflow edge
        irq_chk("race_irq", 1'b1);
        rd_chk("race_tcon", BASE + 32'h08, 32'h7);
        rd_chk("race_tl_reload", BASE + 32'h04, 32'hFFFF_FFFC);

        // ---------------- TL write priority ----------------
        wr_reg(BASE + 32'h08, 32'h3);            // clear STAT; TL FC -> FD
        wr_reg(BASE + 32'h04, 32'hFFFF_FFFF);
        irq_chk("tlw_irq_pre", 1'b0);
        wr_reg(BASE + 32'h04, 32'h0000_0010);    // write on overflow edge
        rd_chk("tlw_tl", BASE + 32'h04, 32'h0000_0010);
        irq_chk("tlw_irq", 1'b1);
        tick();
        rd_chk("tlw_tl_inc", BASE + 32'h04, 32'h0000_0011);
        wr_reg(BASE + 32'h14, 32'h0);
        rd_chk("systick_wr_ignored", BASE + 32'h14, exp_systick);
        tick();
        rd_chk("systick_inc", BASE + 32'h14, exp_systick);

        // ---------------- reset mid-count ----------------
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        irq_chk("midrst_irq", 1'b0);
        rd_chk("midrst_tl", BASE + 32'h04, 32'd0);
        rd_chk("midrst_tcon", BASE + 32'h08, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        rd_chk("midrst_th", BASE + 32'h00, 32'd0);
        rd_chk("midrst_systick", BASE + 32'h14, 32'd0);
        tick();

`ifdef TIMER_PRESCALE_EN
        // ---------------- prescaler ----------------
        wr_reg(BASE + 32'h0C, 32'hFFFF_0002);
        rd_chk("presc_rd", BASE + 32'h0C, 32'h0000_0002);
        wr_reg(BASE + 32'h00, 32'hFFFF_FFFE);
        wr_reg(BASE + 32'h04, 32'hFFFF_FFFE);
        wr_reg(BASE + 32'h08, 32'h3);
        for (int k = 1; k <= 6; k++) begin
            logic [31:0] exp_tl;
            tick();
            exp_tl = (k >= 3 && k <= 5) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
            rd_chk($sformatf("presc_tl_e%0d", k), BASE + 32'h04, exp_tl);
            irq_chk($sformatf("presc_irq_e%0d", k), (k == 6));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
